lc4_dmem_arbiter: RTL
=====================

Name: lc4_dmem_arbiter

Overview:
Shares the single data-memory port of lc4_memory (daddr/din/dout/dwe) between the LC4 processor and a secondary requester (loader/DMA engine).
- Sits between lc4_processor's o_dmem_* / i_cur_dmem_data and the memory block.
- Models a fixed multi-cycle memory access latency and presents a per-transaction request/ack handshake to each side.
- Produces the processor stall indication in the testbench stall encoding (2'd1 = cache/memory stall).

Parameters:
- LATENCY, 2, gwe-qualified cycles the memory port is held per access; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- gwe  in  1  global write enable from lc4_we_gen; all state advances only on clk edges where gwe=1
- i_p_req  in  1  processor request
- i_p_addr  in  16  processor address
- i_p_we  in  1  processor write (1) / read (0)
- i_p_wdata  in  16  processor write data
- o_p_ack  out  1  processor transaction complete (one gwe-cycle pulse)
- o_p_rdata  out  16  processor read data, valid while o_p_ack=1
- i_s_req  in  1  secondary request
- i_s_addr  in  16  secondary address
- i_s_we  in  1  secondary write/read
- i_s_wdata  in  16  secondary write data
- o_s_ack  out  1  secondary transaction complete
- o_s_rdata  out  16  secondary read data, valid while o_s_ack=1
- o_dmem_addr  out  16  memory address
- o_dmem_we  out  1  memory write enable
- o_dmem_towrite  out  16  memory write data
- i_dmem_data  in  16  memory read data
- o_p_stall  out  1  processor is waiting
- o_test_stall  out  2  2'd1 when o_p_stall, else 2'd0

Behaviour:
- Reset: rst applies on any rising clk edge regardless of gwe.
  - State=IDLE, count=0, last_grant=secondary (the processor wins the first tie).
  - All latched fields=0; o_p_ack=o_s_ack=0, o_p_rdata=o_s_rdata=0.
  - o_dmem_addr=0, o_dmem_we=0, o_dmem_towrite=0.
- gwe=0: state, counter, latches and the ack registers hold.
  - o_dmem_we is combinational and is gated by gwe, so no write can occur on a gwe=0 cycle.
- IDLE:
  - No request: remain in IDLE; memory outputs stay 0.
  - One request: grant it.
  - Both requests: grant the requester not in last_grant (round-robin).
  - On grant: latch owner, addr, we and wdata; set last_grant=owner; count=LATENCY-1; go to BUSY.
- BUSY:
  - o_dmem_addr and o_dmem_towrite are driven from the latches.
  - o_dmem_we = latched we & (count==0) & gwe. This gives exactly one write per transaction.
  - count>0: decrement.
  - count==0: capture i_dmem_data into the owner's rdata register; go to RESP.
- RESP:
  - Owner's ack=1 for exactly this one gwe-cycle. The other requester's ack=0.
  - rdata holds its value after RESP and is still 0 (or held) for writes.
  - Next state is always IDLE. A request held high after ack starts a new transaction from IDLE.
- Timing:
  - Latency from request sampled in IDLE to ack = LATENCY+1 gwe-cycles.
  - Back-to-back throughput = one transaction per LATENCY+2 gwe-cycles.
- Requester rule: hold req and fields stable until ack.
  - Changes after the grant are ignored because the latched values are used.
  - If req deasserts mid-transaction, the transaction still completes and still acks.
- Stall: o_p_stall = i_p_req & ~o_p_ack (combinational). o_test_stall = {1'b0, o_p_stall}.
- Reset mid-BUSY: the transaction is abandoned.
  - No ack, no write.
  - The next cycle after rst deasserts is IDLE.
- Counter width is 4 bits; LATENCY outside 1..15 is illegal, and the bench flags it with an initial check.

Test Plan:
- Reset: hold rst 3 cycles with gwe toggling -> all outputs 0, o_test_stall=2'd0.
- Processor read, LATENCY=2, mem[0x4000]=0x1234, i_p_req=1 addr=0x4000 -> o_dmem_addr=0x4000 for 2 gwe-cycles, o_p_ack pulses on the 3rd gwe-cycle with o_p_rdata=0x1234, o_test_stall=2'd1 for the preceding 2 cycles.
- Processor write 0xBEEF to 0x2001 -> o_dmem_we high on exactly one gwe-cycle (the final BUSY cycle), mem[0x2001]=0xBEEF, o_p_ack one pulse.
- Both req held continuously from reset -> grants alternate P,S,P,S; each ack spaced LATENCY+2 gwe-cycles apart; no ack overlap.
- gwe forced 0 for 5 clocks mid-BUSY -> o_dmem_we stays 0, state/count frozen; completion is delayed by exactly the frozen cycles.
- rst asserted during BUSY of a secondary write -> no o_dmem_we pulse, no o_s_ack, memory unchanged; next pending i_p_req is granted from IDLE.

Source files
------------

// File: rtl/lc4_dmem_arbiter_if.sv
// Handshake and memory-port bundle between the LC4 data-memory arbiter,
// its two requesters (processor and secondary engine), and the memory block.
interface lc4_dmem_arbiter_if;
  logic        i_p_req;
  logic [15:0] i_p_addr;
  logic        i_p_we;
  logic [15:0] i_p_wdata;
  logic        o_p_ack;
  logic [15:0] o_p_rdata;

  logic        i_s_req;
  logic [15:0] i_s_addr;
  logic        i_s_we;
  logic [15:0] i_s_wdata;
  logic        o_s_ack;
  logic [15:0] o_s_rdata;

  logic [15:0] o_dmem_addr;
  logic        o_dmem_we;
  logic [15:0] o_dmem_towrite;
  logic [15:0] i_dmem_data;

  logic        o_p_stall;
  logic [1:0]  o_test_stall;

  modport slave (
    input  i_p_req, i_p_addr, i_p_we, i_p_wdata,
    input  i_s_req, i_s_addr, i_s_we, i_s_wdata,
    input  i_dmem_data,
    output o_p_ack, o_p_rdata, o_s_ack, o_s_rdata,
    output o_dmem_addr, o_dmem_we, o_dmem_towrite,
    output o_p_stall, o_test_stall
  );

  modport master (
    output i_p_req, i_p_addr, i_p_we, i_p_wdata,
    output i_s_req, i_s_addr, i_s_we, i_s_wdata,
    output i_dmem_data,
    input  o_p_ack, o_p_rdata, o_s_ack, o_s_rdata,
    input  o_dmem_addr, o_dmem_we, o_dmem_towrite,
    input  o_p_stall, o_test_stall
  );
endinterface

// File: rtl/lc4_dmem_arbiter.sv
// Round-robin arbiter sharing the single LC4 data-memory port between the
// processor and a secondary requester, with a fixed gwe-qualified latency.
module lc4_dmem_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input logic               clk,
  input logic               rst,
  input logic               gwe,
  lc4_dmem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic OWN_P = 1'b0;
  localparam logic OWN_S = 1'b1;

  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  count;
  logic        last_grant;
  logic        owner;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        p_ack;
  logic        s_ack;
  logic [15:0] p_rdata;
  logic [15:0] s_rdata;

  logic        grant_p;
  logic        grant_s;
  logic        last_beat;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_p   = bus.i_p_req & (~bus.i_s_req | (last_grant == OWN_S));
    grant_s   = bus.i_s_req & ~grant_p;
    last_beat = (state == BUSY) && (count == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 4'd0;
      last_grant <= OWN_S;
      owner      <= OWN_P;
      lat_we     <= 1'b0;
      lat_addr   <= 16'h0000;
      lat_wdata  <= 16'h0000;
      p_ack      <= 1'b0;
      s_ack      <= 1'b0;
      p_rdata    <= 16'h0000;
      s_rdata    <= 16'h0000;
    end else if (gwe) begin
      unique case (state)
        IDLE: begin
          if (grant_p || grant_s) begin
            owner      <= grant_s ? OWN_S : OWN_P;
            last_grant <= grant_s ? OWN_S : OWN_P;
            lat_addr   <= grant_s ? bus.i_s_addr  : bus.i_p_addr;
            lat_we     <= grant_s ? bus.i_s_we    : bus.i_p_we;
            lat_wdata  <= grant_s ? bus.i_s_wdata : bus.i_p_wdata;
            count      <= COUNT_INIT;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            // Writes leave the owner's read-data register holding its old value.
            if (!lat_we) begin
              if (owner == OWN_S) s_rdata <= bus.i_dmem_data;
              else                p_rdata <= bus.i_dmem_data;
            end
            p_ack <= (owner == OWN_P);
            s_ack <= (owner == OWN_S);
            state <= RESP;
          end
        end
        RESP: begin
          p_ack <= 1'b0;
          s_ack <= 1'b0;
          state <= IDLE;
        end
        default: begin
          p_ack <= 1'b0;
          s_ack <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // The write strobe also drops under rst so an abandoned transaction never writes.
  assign bus.o_dmem_addr    = (state == BUSY) ? lat_addr  : 16'h0000;
  assign bus.o_dmem_towrite = (state == BUSY) ? lat_wdata : 16'h0000;
  assign bus.o_dmem_we      = lat_we & last_beat & gwe & ~rst;

  assign bus.o_p_ack      = p_ack;
  assign bus.o_s_ack      = s_ack;
  assign bus.o_p_rdata    = p_rdata;
  assign bus.o_s_rdata    = s_rdata;
  assign bus.o_p_stall    = bus.i_p_req & ~p_ack;
  assign bus.o_test_stall = {1'b0, bus.i_p_req & ~p_ack};

endmodule
